// File: rtl/afu_rs_pkg.sv
// Shared types and constants for the TX read burst splitter.
package afu_rs_pkg;

   localparam int CL_ADDR_W   = 58;
   localparam int BURST_LEN_W = 6;
   localparam int MAX_BURST   = 64;

   typedef enum logic {
      RS_IDLE,
      RS_ISSUE
   } t_rs_state;

endpackage

// File: rtl/afu_rs_outstanding_cnt.sv
// In-flight read counter: +1 per issued CL, -1 per returned response.
// A response with nothing outstanding leaves the count at 0 and raises a
// sticky error flag.
module afu_rs_outstanding_cnt #(
   parameter int LIMIT = 32,
   parameter int W     = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         below_limit,
   output logic         err
);

   logic inc_eff;

   // Headroom compare used both by the issuer and as a saturation guard.
   assign below_limit = (cnt < W'(LIMIT));
   assign inc_eff     = inc && below_limit;

   // Counter update with underflow detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (dec && (cnt == '0))
            err <= 1'b1;
         case ({inc_eff, dec})
            2'b10:   cnt <= cnt + W'(1);
            2'b01:   if (cnt != '0) cnt <= cnt - W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/afu_rd_splitter.sv
// Splits one multi-CL read burst from the core into single-CL read requests,
// one per cycle, honouring almost-full backpressure and an outstanding cap.
module afu_rd_splitter
   import afu_rs_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 32,
   parameter int OUT_W           = 7
) (
   input  logic                   clk,
   input  logic                   spl_reset,
   input  logic                   cor_tx_rd_valid,
   input  logic [CL_ADDR_W-1:0]   cor_tx_rd_addr,
   input  logic [BURST_LEN_W-1:0] cor_tx_rd_len,
   output logic                   cor_tx_rd_ready,
   input  logic                   spl_tx_rd_almostfull,
   output logic                   rs_tx_rd_valid,
   output logic [CL_ADDR_W-1:0]   rs_tx_rd_addr,
   output logic [BURST_LEN_W-1:0] rs_tx_rd_idx,
   input  logic                   io_rx_rd_valid,
   output logic                   rs_busy,
   output logic [OUT_W-1:0]       rs_outstanding,
   output logic                   rs_err
);

   t_rs_state              state;
   logic [CL_ADDR_W-1:0]   base;
   logic [BURST_LEN_W-1:0] idx;
   logic [6:0]             remain;   // holds 1..64, so one bit wider than len
   logic                   below_limit;
   logic                   issue_ok;

   // Issue only from registered state so the decision never sees same-cycle
   // responses; the counter absorbs inc/dec collisions itself.
   assign issue_ok = (state == RS_ISSUE) && !spl_tx_rd_almostfull && below_limit;
   assign rs_busy  = (state == RS_ISSUE) || (rs_outstanding != '0);

   afu_rs_outstanding_cnt #(
      .LIMIT (MAX_OUTSTANDING),
      .W     (OUT_W)
   ) u_out_cnt (
      .clk         (clk),
      .rst         (spl_reset),
      .inc         (issue_ok),
      .dec         (io_rx_rd_valid),
      .cnt         (rs_outstanding),
      .below_limit (below_limit),
      .err         (rs_err)
   );

   // Burst FSM with registered handshake and request outputs. Ready is only
   // re-raised from IDLE, which puts one dead cycle after the last request.
   always_ff @(posedge clk) begin
      if (spl_reset) begin
         state           <= RS_IDLE;
         cor_tx_rd_ready <= 1'b1;
         rs_tx_rd_valid  <= 1'b0;
         rs_tx_rd_addr   <= '0;
         rs_tx_rd_idx    <= '0;
         base            <= '0;
         idx             <= '0;
         remain          <= '0;
      end else begin
         rs_tx_rd_valid <= 1'b0;
         case (state)
            RS_IDLE: begin
               if (cor_tx_rd_valid && cor_tx_rd_ready) begin
                  base            <= cor_tx_rd_addr;
                  remain          <= (cor_tx_rd_len == '0) ? 7'(MAX_BURST)
                                                           : {1'b0, cor_tx_rd_len};
                  idx             <= '0;
                  state           <= RS_ISSUE;
                  cor_tx_rd_ready <= 1'b0;
               end else begin
                  cor_tx_rd_ready <= 1'b1;
               end
            end
            RS_ISSUE: begin
               cor_tx_rd_ready <= 1'b0;
               if (issue_ok) begin
                  rs_tx_rd_valid <= 1'b1;
                  rs_tx_rd_addr  <= base + CL_ADDR_W'(idx);
                  rs_tx_rd_idx   <= idx;
                  idx            <= idx + 6'd1;
                  remain         <= remain - 7'd1;
                  if (remain == 7'd1)
                     state <= RS_IDLE;
               end
            end
            default: state <= RS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_afu_rd_splitter.sv
// Self-checking bench: a scoreboard of expected (addr, idx) requests is filled
// when a burst is driven and drained by a monitor on the falling edge.
module tb_afu_rd_splitter;

   typedef struct packed {
      logic [57:0] addr;
      logic [5:0]  idx;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic spl_reset;

   // DUT A: large outstanding cap
   logic        a_cvalid, a_cready, a_af, a_valid, a_rx, a_busy, a_err;
   logic [57:0] a_caddr, a_addr;
   logic [5:0]  a_clen, a_idx;
   logic [6:0]  a_out;

   // DUT B: small cap for the throttling scenario
   logic        b_cvalid, b_cready, b_af, b_valid, b_rx, b_busy, b_err;
   logic [57:0] b_caddr, b_addr;
   logic [5:0]  b_clen, b_idx;
   logic [6:0]  b_out;

   int errors = 0;
   int checks = 0;
   int mon_pulses = 0;
   exp_t exp_q[$];

   afu_rd_splitter #(.MAX_OUTSTANDING(127), .OUT_W(7)) dut_a (
      .clk(clk), .spl_reset(spl_reset),
      .cor_tx_rd_valid(a_cvalid), .cor_tx_rd_addr(a_caddr), .cor_tx_rd_len(a_clen),
      .cor_tx_rd_ready(a_cready), .spl_tx_rd_almostfull(a_af),
      .rs_tx_rd_valid(a_valid), .rs_tx_rd_addr(a_addr), .rs_tx_rd_idx(a_idx),
      .io_rx_rd_valid(a_rx), .rs_busy(a_busy), .rs_outstanding(a_out), .rs_err(a_err)
   );

   afu_rd_splitter #(.MAX_OUTSTANDING(8), .OUT_W(7)) dut_b (
      .clk(clk), .spl_reset(spl_reset),
      .cor_tx_rd_valid(b_cvalid), .cor_tx_rd_addr(b_caddr), .cor_tx_rd_len(b_clen),
      .cor_tx_rd_ready(b_cready), .spl_tx_rd_almostfull(b_af),
      .rs_tx_rd_valid(b_valid), .rs_tx_rd_addr(b_addr), .rs_tx_rd_idx(b_idx),
      .io_rx_rd_valid(b_rx), .rs_busy(b_busy), .rs_outstanding(b_out), .rs_err(b_err)
   );

   // Scoreboard monitor for DUT A
   always @(negedge clk) begin
      exp_t e;
      if (a_valid === 1'b1) begin
         mon_pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req addr=%h idx=%0d (no request expected)", a_addr, a_idx);
         end else begin
            e = exp_q.pop_front();
            if (a_addr !== e.addr || a_idx !== e.idx) begin
               errors++;
               $display("FAIL req_order got addr=%h idx=%0d want addr=%h idx=%0d",
                        a_addr, a_idx, e.addr, e.idx);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst(input logic [57:0] base, input logic [5:0] len);
      exp_t e;
      int n;
      n = (len == 6'd0) ? 64 : int'(len);
      for (int i = 0; i < n; i++) begin
         e.addr = base + 58'(i);
         e.idx  = 6'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic start_burst(input logic [57:0] base, input logic [5:0] len);
      push_burst(base, len);
      a_cvalid = 1'b1;
      a_caddr  = base;
      a_clen   = len;
      tick();
      a_cvalid = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || a_cready !== 1'b1) && n < bound) begin
         tick();
         n++;
      end
      checks++;
      if (n >= bound) begin
         errors++;
         $display("FAIL burst_timeout pending=%0d ready=%b after %0d cycles", exp_q.size(), a_cready, n);
      end
   endtask

   task automatic drain(input int n);
      a_rx = 1'b1;
      repeat (n) tick();
      a_rx = 1'b0;
   endtask

   task automatic test_reset();
      spl_reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({a_cready, a_valid, a_busy, a_err} !== 4'b1000 || a_addr !== 58'd0 ||
          a_idx !== 6'd0 || a_out !== 7'd0) begin
         errors++;
         $display("FAIL reset_state rdy=%b vld=%b busy=%b err=%b addr=%h idx=%0d out=%0d want 1,0,0,0,0,0,0",
                  a_cready, a_valid, a_busy, a_err, a_addr, a_idx, a_out);
      end
      spl_reset = 1'b0;
      tick();
      checks++;
      if (a_cready !== 1'b1 || a_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle rdy=%b vld=%b want 1,0", a_cready, a_valid);
      end
   endtask

   task automatic test_basic();
      start_burst(58'h100, 6'd4);
      checks++;
      if (a_valid !== 1'b0 || a_cready !== 1'b0) begin
         errors++;
         $display("FAIL accept_cycle vld=%b rdy=%b want 0,0", a_valid, a_cready);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (a_valid !== 1'b1 || a_cready !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse%0d vld=%b rdy=%b want 1,0", k, a_valid, a_cready);
         end
      end
      tick();
      checks++;
      if (a_valid !== 1'b0 || a_cready !== 1'b1 || a_out !== 7'd4 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_end vld=%b rdy=%b out=%0d busy=%b want 0,1,4,1", a_valid, a_cready, a_out, a_busy);
      end
      drain(4);
      checks++;
      if (a_out !== 7'd0 || a_busy !== 1'b0 || a_err !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_drain out=%0d busy=%b err=%b pend=%0d want 0,0,0,0", a_out, a_busy, a_err, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      start_burst(58'h3FF_FFFF_FFFF_FFFE, 6'd0);
      wait_done(300);
      checks++;
      if (a_out !== 7'd64) begin
         errors++;
         $display("FAIL wrap_outstanding got %0d want 64", a_out);
      end
      drain(64);
      checks++;
      if (a_out !== 7'd0 || a_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_drain out=%0d err=%b want 0,0", a_out, a_err);
      end
   endtask

   task automatic test_almostfull();
      int p0;
      p0 = mon_pulses;
      start_burst(58'h2000, 6'd10);
      tick();
      checks++;
      if (a_valid !== 1'b1) begin
         errors++;
         $display("FAIL af_first vld=%b want 1", a_valid);
      end
      a_af = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL af_stall%0d vld=%b want 0", k, a_valid);
         end
      end
      a_af = 1'b0;
      wait_done(100);
      checks++;
      if (mon_pulses - p0 != 10 || a_out !== 7'd10) begin
         errors++;
         $display("FAIL af_count pulses=%0d out=%0d want 10,10", mon_pulses - p0, a_out);
      end
      drain(10);
   endtask

   task automatic test_same_cycle();
      start_burst(58'h40, 6'd6);
      repeat (5) tick();
      checks++;
      if (a_out !== 7'd5) begin
         errors++;
         $display("FAIL same_pre out=%0d want 5", a_out);
      end
      a_rx = 1'b1;
      tick();
      a_rx = 1'b0;
      checks++;
      if (a_out !== 7'd5 || a_valid !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle out=%0d vld=%b want 5,1", a_out, a_valid);
      end
      wait_done(50);
      drain(5);
      checks++;
      if (a_out !== 7'd0 || a_err !== 1'b0) begin
         errors++;
         $display("FAIL same_drain out=%0d err=%b want 0,0", a_out, a_err);
      end
      a_rx = 1'b1;
      tick();
      a_rx = 1'b0;
      tick();
      checks++;
      if (a_err !== 1'b1 || a_out !== 7'd0) begin
         errors++;
         $display("FAIL underflow err=%b out=%0d want 1,0", a_err, a_out);
      end
   endtask

   task automatic test_limit();
      int cnt;
      b_cvalid = 1'b1;
      b_caddr  = 58'h800;
      b_clen   = 6'd16;
      tick();
      b_cvalid = 1'b0;
      cnt = 0;
      repeat (20) begin
         tick();
         if (b_valid === 1'b1) cnt++;
      end
      checks++;
      if (cnt != 8 || b_out !== 7'd8 || b_cready !== 1'b0) begin
         errors++;
         $display("FAIL limit_stall pulses=%0d out=%0d rdy=%b want 8,8,0", cnt, b_out, b_cready);
      end
      cnt = 0;
      repeat (3) begin
         b_rx = 1'b1;
         tick();
         if (b_valid === 1'b1) cnt++;
         b_rx = 1'b0;
         repeat (3) begin
            tick();
            if (b_valid === 1'b1) cnt++;
         end
      end
      checks++;
      if (cnt != 3 || b_out !== 7'd8 || b_err !== 1'b0) begin
         errors++;
         $display("FAIL limit_resume pulses=%0d out=%0d err=%b want 3,8,0", cnt, b_out, b_err);
      end
   endtask

   task automatic test_reset_mid();
      start_burst(58'h500, 6'd8);
      repeat (3) tick();
      spl_reset = 1'b1;
      tick();
      exp_q.delete();
      checks++;
      if ({a_cready, a_valid, a_busy, a_err} !== 4'b1000 || a_addr !== 58'd0 ||
          a_idx !== 6'd0 || a_out !== 7'd0) begin
         errors++;
         $display("FAIL reset_mid rdy=%b vld=%b busy=%b err=%b addr=%h idx=%0d out=%0d want 1,0,0,0,0,0,0",
                  a_cready, a_valid, a_busy, a_err, a_addr, a_idx, a_out);
      end
      spl_reset = 1'b0;
      start_burst(58'h600, 6'd2);
      checks++;
      if (a_cready !== 1'b0) begin
         errors++;
         $display("FAIL reset_reaccept rdy=%b want 0", a_cready);
      end
      wait_done(50);
      checks++;
      if (a_out !== 7'd2) begin
         errors++;
         $display("FAIL reset_newburst out=%0d want 2", a_out);
      end
   endtask

   initial begin
      spl_reset = 1'b1;
      a_cvalid = 1'b0; a_caddr = '0; a_clen = '0; a_af = 1'b0; a_rx = 1'b0;
      b_cvalid = 1'b0; b_caddr = '0; b_clen = '0; b_af = 1'b0; b_rx = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_almostfull();
      test_same_cycle();
      test_limit();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
